e_muldiv: RTL and testbench
===========================

E_MULDIV -- requirements
Module: e_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have parameter MULT_LAT, default 5, multiply latency in cycles (>=1).
REQ-003 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-high reset.
REQ-004 SHALL have port flush input 1, cancels the in-flight operation (E/M-stage exception).
REQ-005 SHALL have ports rs input WIDTH and rt input WIDTH, operands.
REQ-006 SHALL have port op input 4, operation code (MULDIV_OP_* constants); NONE = idle.
REQ-007 SHALL have port busy output 1, stall request to hazard unit.
REQ-008 SHALL have port result output WIDTH, MFHI/MFLO read data.

Function
REQ-009 SHALL decode ops NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO (plus MADD group, REQ-027).
REQ-010 SHALL have FSM states IDLE, MUL, DIV; only IDLE accepts ops.
REQ-011 SHALL in IDLE on MTHI/MTLO write rs to HI/LO at that edge; no busy.
REQ-012 SHALL drive result combinationally: MFHI -> HI, MFLO -> LO, else 0; reads see state as of current cycle.
REQ-013 SHALL in IDLE on MULT/MULTU capture rs, rt, go to MUL, load counter = MULT_LAT.
REQ-014 SHALL write {HI,LO} = 2*WIDTH-bit signed (MULT) / unsigned (MULTU) product at the MULT_LAT-th edge after issue, returning to IDLE.
REQ-015 SHALL in IDLE on DIV/DIVU go to DIV and run iterative restoring division in sub-module, one quotient bit per cycle.
REQ-016 SHALL write LO = quotient, HI = remainder at edge WIDTH+1 after issue; signed: quotient truncates toward zero, remainder sign follows dividend.
REQ-017 SHALL for divide by zero write LO = all ones, HI = rs; latency unchanged.
REQ-018 SHALL for signed DIV of most-negative by -1 write LO = most-negative, HI = 0.
REQ-019 SHALL assert busy = (op is MULT/MULTU/DIV/DIVU/MADD-group in IDLE and not flush) OR (state != IDLE), deasserting the cycle after HI/LO write.
REQ-020 SHALL ignore any op presented while state != IDLE (stall contract; no side effect).
REQ-021 SHALL on flush return to IDLE at next edge, discard in-flight result, leave HI/LO unchanged.
REQ-022 SHALL give flush priority over a same-cycle op: op (including MTHI/MTLO) not accepted.
REQ-023 SHALL give flush on the completion edge priority: HI/LO not written.

Reset
REQ-024 SHALL on reset clear HI, LO, counter, operand/partial registers to 0, state to IDLE; busy = 0, result = 0 next cycle.
REQ-025 SHALL give reset priority over flush and op, aborting any operation mid-flight.
REQ-026 SHALL not depend on initial blocks for functional reset.

Configuration
REQ-027 SHALL with MULDIV_MADD_EN defined support MADD/MADDU/MSUB/MSUBU: {HI,LO} +/- signed/unsigned product, modulo 2^(2*WIDTH), latency MULT_LAT, accumulator value sampled at issue.
REQ-028 SHALL without MULDIV_MADD_EN treat MADD-group codes as NONE (no busy, no state change).

Structure
REQ-029 SHALL place MULDIV_OP_* opcode constants in the shared const.v header, used by decoder and this block.
REQ-030 SHALL implement division in sub-module e_muldiv_div (start, signed flag, dividend, divisor -> done, quotient, remainder; abort input driven by flush/reset).

Verification
REQ-031 SHALL cover: MULT rs=0xFFFFFFFE, rt=3 -> busy 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA at edge 5; MULTU same -> HI=0x2, LO=0xFFFFFFFA.
REQ-032 SHALL cover: DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at edge 33; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 SHALL cover: MTHI 0x1234 then MFHI next cycle -> result=0x1234; MTLO during busy -> LO unchanged.
REQ-034 SHALL cover: DIV issued, flush at cycle 10 -> busy low after next edge, HI/LO keep prior values; flush with MULT same cycle -> busy never high.
REQ-035 SHALL cover: reset at cycle 3 of MULT -> HI=LO=0, busy=0; MADD (EN) with HI:LO=0:5, rs=2, rt=3 -> LO=11; without EN -> no change.

Source files
------------

// File: rtl/e_muldiv_pkg.sv
// Shared opcodes, FSM states and multiply-decode helper for the e_muldiv HI/LO unit.
// MULDIV_OP_* values are shared with the instruction decoder.
package e_muldiv_pkg;

    localparam logic [3:0] MULDIV_OP_NONE  = 4'd0;
    localparam logic [3:0] MULDIV_OP_MULT  = 4'd1;
    localparam logic [3:0] MULDIV_OP_MULTU = 4'd2;
    localparam logic [3:0] MULDIV_OP_DIV   = 4'd3;
    localparam logic [3:0] MULDIV_OP_DIVU  = 4'd4;
    localparam logic [3:0] MULDIV_OP_MFHI  = 4'd5;
    localparam logic [3:0] MULDIV_OP_MFLO  = 4'd6;
    localparam logic [3:0] MULDIV_OP_MTHI  = 4'd7;
    localparam logic [3:0] MULDIV_OP_MTLO  = 4'd8;
    localparam logic [3:0] MULDIV_OP_MADD  = 4'd9;
    localparam logic [3:0] MULDIV_OP_MADDU = 4'd10;
    localparam logic [3:0] MULDIV_OP_MSUB  = 4'd11;
    localparam logic [3:0] MULDIV_OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    typedef struct packed {
        logic is_signed;
        logic accumulate;
        logic subtract;
    } mul_cfg_t;

    function automatic mul_cfg_t decode_mul(input logic [3:0] code);
        mul_cfg_t cfg;
        cfg = '0;
        case (code)
            MULDIV_OP_MULT:  cfg.is_signed = 1'b1;
            MULDIV_OP_MADD:  begin cfg.is_signed = 1'b1; cfg.accumulate = 1'b1; end
            MULDIV_OP_MADDU: cfg.accumulate = 1'b1;
            MULDIV_OP_MSUB:  begin cfg.is_signed = 1'b1; cfg.accumulate = 1'b1; cfg.subtract = 1'b1; end
            MULDIV_OP_MSUBU: begin cfg.accumulate = 1'b1; cfg.subtract = 1'b1; end
            default:         cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/e_muldiv_div.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, sign fix-up on
// the final step so the result is ready on the WIDTH-th edge after start.
module e_muldiv_div
    import e_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             run_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] dividend_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             dz_reg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    // Shift in the next dividend bit; subtract only when it does not borrow.
    assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
    assign borrow   = shifted < {1'b0, dvs_reg};
    assign rem_sub  = shifted[WIDTH-1:0] - dvs_reg;
    assign rem_step = borrow ? shifted[WIDTH-1:0] : rem_sub;
    assign quo_step = {quo_reg[WIDTH-2:0], ~borrow};

    assign done      = run_reg && (count_reg == CW'(1)) && !abort;
    assign quotient  = dz_reg ? '1 : (neg_q_reg ? -quo_step : quo_step);
    assign remainder = dz_reg ? dividend_reg : (neg_r_reg ? -rem_step : rem_step);

    always_ff @(posedge clk) begin
        if (reset) begin
            run_reg      <= 1'b0;
            count_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvs_reg      <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dz_reg       <= 1'b0;
        end else if (abort) begin
            run_reg <= 1'b0;
        end else if (start) begin
            run_reg      <= 1'b1;
            count_reg    <= CW'(WIDTH);
            rem_reg      <= '0;
            quo_reg      <= a_mag;
            dvs_reg      <= b_mag;
            dividend_reg <= dividend;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            dz_reg       <= (divisor == '0);
        end else if (run_reg) begin
            rem_reg   <= rem_step;
            quo_reg   <= quo_step;
            count_reg <= count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/e_muldiv.sv
// HI/LO multiply/divide unit with stall, flush and MFHI/MFLO read port.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate group.
module e_muldiv
    import e_muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [3:0]       op,
    output logic             busy,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(MULT_LAT + 1) + 1;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic [WIDTH-1:0]   mul_a_reg, mul_a_next;
    logic [WIDTH-1:0]   mul_b_reg, mul_b_next;
    mul_cfg_t           mul_cfg_reg, mul_cfg_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic               in_idle;
    logic               is_mul_group;
    logic               is_div;
    logic               div_start;
    logic               div_done;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    mul_cfg_t           cfg;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mul_out;

`ifdef MULDIV_MADD_EN
    assign is_mul_group = op inside {MULDIV_OP_MULT, MULDIV_OP_MULTU, MULDIV_OP_MADD,
                                     MULDIV_OP_MADDU, MULDIV_OP_MSUB, MULDIV_OP_MSUBU};
`else
    assign is_mul_group = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU);
`endif

    assign is_div    = (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
    assign in_idle   = (state_reg == ST_IDLE);
    assign div_start = in_idle && !flush && is_div;
    assign busy      = (in_idle && !flush && (is_mul_group || is_div)) || !in_idle;

    // Operands come straight from the ports at issue (covers MULT_LAT == 1), else from the capture.
    assign op_a  = in_idle ? rs : mul_a_reg;
    assign op_b  = in_idle ? rt : mul_b_reg;
    assign cfg   = in_idle ? decode_mul(op) : mul_cfg_reg;
    assign ext_a = {{WIDTH{cfg.is_signed & op_a[WIDTH-1]}}, op_a};
    assign ext_b = {{WIDTH{cfg.is_signed & op_b[WIDTH-1]}}, op_b};
    assign product = ext_a * ext_b;

    // HI/LO cannot change while a multiply is in flight, so this equals the value at issue.
    assign acc = {hi_reg, lo_reg};
    assign mul_out = cfg.accumulate ? (cfg.subtract ? acc - product : acc + product) : product;

    always_comb begin
        result = '0;
        if (op == MULDIV_OP_MFHI) begin
            result = hi_reg;
        end else if (op == MULDIV_OP_MFLO) begin
            result = lo_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        mul_a_next   = mul_a_reg;
        mul_b_next   = mul_b_reg;
        mul_cfg_next = mul_cfg_reg;
        count_next   = count_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (!flush) begin
                    if (op == MULDIV_OP_MTHI) begin
                        hi_next = rs;
                    end else if (op == MULDIV_OP_MTLO) begin
                        lo_next = rs;
                    end else if (is_mul_group) begin
                        if (MULT_LAT == 1) begin
                            {hi_next, lo_next} = mul_out;
                        end else begin
                            state_next   = ST_MUL;
                            count_next   = CNT_W'(MULT_LAT);
                            mul_a_next   = rs;
                            mul_b_next   = rt;
                            mul_cfg_next = decode_mul(op);
                        end
                    end else if (is_div) begin
                        state_next = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (count_reg == CNT_W'(2)) begin
                    {hi_next, lo_next} = mul_out;
                    state_next         = ST_IDLE;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (div_done) begin
                    lo_next    = div_q;
                    hi_next    = div_r;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            hi_reg      <= '0;
            lo_reg      <= '0;
            mul_a_reg   <= '0;
            mul_b_reg   <= '0;
            mul_cfg_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            mul_a_reg   <= mul_a_next;
            mul_b_reg   <= mul_b_next;
            mul_cfg_reg <= mul_cfg_next;
            count_reg   <= count_next;
        end
    end

    e_muldiv_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (flush | reset),
        .signed_op (op == MULDIV_OP_DIV),
        .dividend  (rs),
        .divisor   (rt),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

endmodule

// File: tb/tb_e_muldiv.sv
// Bench for e_muldiv: vector table with a scoreboard queue, plus flush/reset/stall sequences.
module tb_e_muldiv;
    import e_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  op;
    logic        busy;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    e_muldiv dut (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .rs     (rs),
        .rt     (rt),
        .op     (op),
        .busy   (busy),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [31:0] h, input logic [31:0] l);
        op = MULDIV_OP_MTHI; rs = h;
        next_cycle();
        op = MULDIV_OP_MTLO; rs = l;
        next_cycle();
        op = MULDIV_OP_NONE; rs = '0;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        op = MULDIV_OP_MFHI; #1; h = result;
        op = MULDIV_OP_MFLO; #1; l = result;
        op = MULDIV_OP_NONE; #1;
    endtask

    task automatic add_vec(input logic [3:0] o, input logic [31:0] ph, input logic [31:0] pl,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input int lat);
        vec_t v;
        v.op = o; v.pre_hi = ph; v.pre_lo = pl; v.rs = a; v.rt = b;
        v.exp_hi = eh; v.exp_lo = el; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] h, l;
        int cnt;
        bit seen;

        reset = 1'b1; flush = 1'b0; op = MULDIV_OP_NONE; rs = '0; rt = '0;

        add_vec(MULDIV_OP_MULT,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        add_vec(MULDIV_OP_MULTU, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
        add_vec(MULDIV_OP_MULT,  32'h1, 32'h2, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5);
        add_vec(MULDIV_OP_MULTU, 32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        add_vec(MULDIV_OP_MULT,  32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5);
        add_vec(MULDIV_OP_DIV,   32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        add_vec(MULDIV_OP_DIVU,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 33);
        add_vec(MULDIV_OP_DIV,   32'h1, 32'h2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
        add_vec(MULDIV_OP_DIV,   32'h1, 32'h2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
        add_vec(MULDIV_OP_DIVU,  32'h1, 32'h2, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 33);
        add_vec(MULDIV_OP_DIV,   32'h1, 32'h2, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 33);
`ifdef MULDIV_MADD_EN
        add_vec(MULDIV_OP_MADD,  32'h0, 32'h5, 32'd2, 32'd3, 32'h00000000, 32'h0000000B, 5);
        add_vec(MULDIV_OP_MSUB,  32'h0, 32'h5, 32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
        add_vec(MULDIV_OP_MADDU, 32'h0, 32'h5, 32'hFFFFFFFF, 32'd2, 32'h00000002, 32'h00000003, 5);
        add_vec(MULDIV_OP_MADD,  32'h0, 32'h5, 32'hFFFFFFFF, 32'd2, 32'h00000000, 32'h00000003, 5);
`else
        add_vec(MULDIV_OP_MADD,  32'h0, 32'h5, 32'd2, 32'd3, 32'h00000000, 32'h00000005, 0);
        add_vec(MULDIV_OP_MSUBU, 32'h0, 32'h5, 32'd2, 32'd3, 32'h00000000, 32'h00000005, 0);
`endif

        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        read_hilo(h, l);
        check("reset_hi", h, 32'h0);
        check("reset_lo", l, 32'h0);
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            exp_t e;
            int cycles;
            logic [31:0] last_lo;
            v = vecs[i];
            cycles = 0;
            last_lo = v.pre_lo;
            mt(v.pre_hi, v.pre_lo);
            op = v.op; rs = v.rs; rt = v.rt;
            e.hi = v.exp_hi; e.lo = v.exp_lo; e.lat = v.lat;
            sb.push_back(e);
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (!busy) break;
                cycles++;
                if (c > 0) last_lo = result;
                @(posedge clk);
                #1;
                op = MULDIV_OP_MFLO; rs = '0; rt = '0;
            end
            e = sb.pop_front();
            read_hilo(h, l);
            $display("vec %0d op=%0d rs=%h rt=%h hi=%h lo=%h busy_cycles=%0d", i, v.op, v.rs, v.rt, h, l, cycles);
            check($sformatf("vec%0d_latency", i), 32'(cycles), 32'(e.lat));
            check($sformatf("vec%0d_hi", i), h, e.hi);
            check($sformatf("vec%0d_lo", i), l, e.lo);
            if (cycles >= 2) check($sformatf("vec%0d_lo_before_write", i), last_lo, v.pre_lo);
            next_cycle();
        end

        // MTHI then MFHI on the following cycle.
        op = MULDIV_OP_MTHI; rs = 32'h1234;
        #1;
        check("mthi_busy", {31'b0, busy}, 32'h0);
        next_cycle();
        op = MULDIV_OP_MFHI; rs = '0;
        #1;
        check("mfhi_after_mthi", result, 32'h1234);
        $display("seq mthi/mfhi result=%h", result);
        op = MULDIV_OP_NONE;
        next_cycle();

        // MTLO presented while a multiply is busy is ignored.
        mt(32'h0, 32'h0);
        op = MULDIV_OP_MULT; rs = 32'd2; rt = 32'd3;
        next_cycle();
        op = MULDIV_OP_MTLO; rs = 32'hDEAD;
        next_cycle();
        op = MULDIV_OP_NONE; rs = '0;
        cnt = 0;
        while (busy && cnt < 50) begin next_cycle(); cnt++; end
        check("mtlo_busy_bounded", {31'b0, busy}, 32'h0);
        read_hilo(h, l);
        $display("seq mtlo-during-busy hi=%h lo=%h", h, l);
        check("mtlo_busy_lo", l, 32'h6);
        check("mtlo_busy_hi", h, 32'h0);
        next_cycle();

        // Flush in cycle 10 of a divide.
        mt(32'h11, 32'h22);
        op = MULDIV_OP_DIV; rs = 32'd100; rt = 32'd3;
        next_cycle();
        op = MULDIV_OP_NONE; rs = '0; rt = '0;
        repeat (8) next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("div_flush_busy_before", {31'b0, busy}, 32'h1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("div_flush_busy_after", {31'b0, busy}, 32'h0);
        read_hilo(h, l);
        check("div_flush_hi", h, 32'h11);
        check("div_flush_lo", l, 32'h22);
        repeat (40) next_cycle();
        read_hilo(h, l);
        $display("seq div-flush hi=%h lo=%h", h, l);
        check("div_flush_late_hi", h, 32'h11);
        check("div_flush_late_lo", l, 32'h22);

        // Flush with MULT (and with MTHI) in the same cycle.
        op = MULDIV_OP_MULT; rs = 32'd3; rt = 32'd3; flush = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        seen = seen | busy;
        next_cycle();
        op = MULDIV_OP_NONE; flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen = seen | busy;
            next_cycle();
        end
        check("flush_mult_busy_never", {31'b0, seen}, 32'h0);
        op = MULDIV_OP_MTHI; rs = 32'h99; flush = 1'b1;
        next_cycle();
        op = MULDIV_OP_NONE; flush = 1'b0; rs = '0;
        read_hilo(h, l);
        $display("seq flush-same-cycle hi=%h lo=%h", h, l);
        check("flush_mthi_hi", h, 32'h11);
        check("flush_mult_lo", l, 32'h22);
        next_cycle();

        // Flush on the completion edge of a multiply.
        mt(32'h33, 32'h44);
        op = MULDIV_OP_MULT; rs = 32'd2; rt = 32'd3;
        next_cycle();
        op = MULDIV_OP_NONE;
        repeat (3) next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("done_flush_busy_before", {31'b0, busy}, 32'h1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("done_flush_busy_after", {31'b0, busy}, 32'h0);
        read_hilo(h, l);
        $display("seq flush-on-completion hi=%h lo=%h", h, l);
        check("done_flush_hi", h, 32'h33);
        check("done_flush_lo", l, 32'h44);
        next_cycle();

        // Reset in cycle 3 of a multiply.
        mt(32'h55, 32'h66);
        op = MULDIV_OP_MULT; rs = 32'd7; rt = 32'd9;
        next_cycle();
        op = MULDIV_OP_NONE;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_busy", {31'b0, busy}, 32'h0);
        read_hilo(h, l);
        check("mid_reset_hi", h, 32'h0);
        check("mid_reset_lo", l, 32'h0);
        repeat (6) next_cycle();
        read_hilo(h, l);
        $display("seq reset-mid-mult hi=%h lo=%h", h, l);
        check("mid_reset_late_lo", l, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
